// File: rtl/node_sequencer.sv
// Request sequencer for a node datapath: accepts a feature vector, issues it,
// waits for the result with a timeout, and holds it for the consumer.
module node_sequencer #(
  parameter int NUM_W   = 28,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_addr,
  input  logic signed [4:0]   cfg_data,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [19:0]         req_x,
  output logic [19:0]         node_x,
  output logic [5*NUM_W-1:0]  node_w,
  output logic                node_in_ready,
  input  logic                node_out_ready,
  input  logic [16:0]         node_out0,
  input  logic [16:0]         node_out1,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [16:0]         res_out0,
  output logic [16:0]         res_out1,
  output logic                busy,
  output logic                timeout_err,
  output logic                cfg_drop
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [19:0]   x_q;
  logic [4:0]    w_q [NUM_W];
  logic [16:0]   out0_q;
  logic [16:0]   out1_q;
  logic          terr_q;
  logic          drop_q;

  logic idle;
  logic cfg_ok;

  assign idle   = (state_q == S_IDLE);
  assign cfg_ok = cfg_we && idle && (int'(cfg_addr) < NUM_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      terr_q  <= 1'b0;
      drop_q  <= 1'b0;
      for (int i = 0; i < NUM_W; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      drop_q <= cfg_we && !cfg_ok;
      // Weight writes land at the same edge as acceptance, so they apply
      if (cfg_ok) begin
        w_q[cfg_addr] <= cfg_data;
      end
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            x_q     <= req_x;
            terr_q  <= 1'b0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (node_out_ready) begin
            out0_q  <= node_out0;
            out1_q  <= node_out1;
            state_q <= S_HOLD;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            terr_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_W; i++) begin : g_w
    assign node_w[5*i +: 5] = w_q[i];
  end

  assign req_ready     = idle;
  assign busy          = !idle;
  assign node_in_ready = (state_q == S_ISSUE);
  assign res_valid     = (state_q == S_HOLD);
  assign node_x        = x_q;
  assign res_out0      = out0_q;
  assign res_out1      = out1_q;
  assign timeout_err   = terr_q;
  assign cfg_drop      = drop_q;

endmodule

// File: doc/node_sequencer.md
NODE_SEQUENCER -- requirements
Module: node_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_W, default 28: number of 5-bit weight registers (w04..w37 at addresses 0-15, w48,w58,w49,w59,w68,w69,w78,w79 at 16-23, spare at 24-27).
REQ-002 The block SHALL have parameter TIMEOUT, default 8: maximum cycles in WAIT before abort.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port cfg_we, input, 1 bit: weight write strobe.
REQ-006 The block SHALL have port cfg_addr, input, 5 bits: weight register index.
REQ-007 The block SHALL have port cfg_data, input, 5 bits, signed: weight value.
REQ-008 The block SHALL have port req_valid, input, 1 bit: an inference request is offered.
REQ-009 The block SHALL have port req_ready, output, 1 bit: the request is accepted this cycle.
REQ-010 The block SHALL have port req_x, input, 20 bits: x0..x3 packed, x0 in [4:0].
REQ-011 The block SHALL have port node_x, output, 20 bits: latched features to the node datapath.
REQ-012 The block SHALL have port node_w, output, 5*NUM_W bits: weight bank, entry i in [5i+4:5i].
REQ-013 The block SHALL have port node_in_ready, output, 1 bit: start pulse to the datapath.
REQ-014 The block SHALL have port node_out_ready, input, 1 bit: datapath result valid.
REQ-015 The block SHALL have ports node_out0 and node_out1, inputs, 17 bits each: datapath results.
REQ-016 The block SHALL have port res_valid, output, 1 bit: a result is held.
REQ-017 The block SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-018 The block SHALL have ports res_out0 and res_out1, outputs, 17 bits each: captured results.
REQ-019 The block SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-020 The block SHALL have port timeout_err, output, 1 bit: sticky abort flag.
REQ-021 The block SHALL have port cfg_drop, output, 1 bit: one-cycle pulse for each rejected config write.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT and HOLD; in IDLE, req_ready=1; IDLE SHALL go to ISSUE on req_valid&&req_ready, latching req_x into node_x.
REQ-023 ISSUE SHALL last exactly one cycle with node_in_ready=1, then go to WAIT; node_in_ready SHALL be 0 in all other states.
REQ-024 node_x SHALL stay stable from acceptance until the next acceptance.
REQ-025 WAIT SHALL clear the wait counter on entry and increment it each cycle; on node_out_ready=1 it SHALL capture node_out0/1 into res_out0/1 and go to HOLD.
REQ-026 If the counter reaches TIMEOUT with no node_out_ready, WAIT SHALL set timeout_err and go to IDLE, with no result and res_out unchanged.
REQ-027 If node_out_ready and the timeout coincide, capture SHALL win: go to HOLD and do not set timeout_err.
REQ-028 In HOLD, res_valid=1 and res_out SHALL be stable; on res_ready=1, HOLD SHALL go to IDLE; res_valid SHALL be 0 elsewhere.
REQ-029 req_ready SHALL be 0 outside IDLE, so a request arriving while the result is consumed is accepted on the next cycle at the earliest.
REQ-030 Minimum request-to-result latency SHALL be 1 (ISSUE) + the datapath latency (3 cycles after node_in_ready) + 1 capture cycle, with res_valid first high 5 cycles after acceptance.
REQ-031 node_out_ready seen outside WAIT SHALL be ignored.
REQ-032 cfg_we in IDLE with cfg_addr<NUM_W SHALL write the entry, visible on node_w next cycle.
REQ-033 cfg_we with cfg_addr>=NUM_W or state!=IDLE SHALL leave the bank unchanged and pulse cfg_drop.
REQ-034 A cfg write in the same cycle as a request acceptance SHALL be applied, and the new weight SHALL be used by that request.
REQ-035 timeout_err SHALL clear only on rst or on the next accepted request.

Reset
REQ-036 On rst=1 at a clock edge, in any state including mid-WAIT or HOLD, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-037 Reset SHALL drive res_valid, node_in_ready, timeout_err, cfg_drop, busy, node_x, res_out0/1 and all node_w entries to 0.
REQ-038 rst SHALL have priority over every other input in the same cycle.

Verification
REQ-039 Bench SHALL cover: write addr 0 = 5'h03, then issue req_x=20'h00001 with a model asserting out_ready 3 cycles after in_ready with out0=17'd3 -> node_w[4:0]=3, single in_ready pulse, res_valid at +5 with res_out0=3.
REQ-040 Bench SHALL cover: res_ready held 0 for 4 cycles in HOLD -> res_valid and res_out stable, req_ready=0 throughout, and a new request accepted the cycle after res_ready.
REQ-041 Bench SHALL cover: node_out_ready never asserted -> timeout_err=1 after TIMEOUT=8 WAIT cycles, back in IDLE, res_valid never 1, and the next request clears timeout_err.
REQ-042 Bench SHALL cover: node_out_ready on the exact timeout cycle -> result captured and timeout_err=0.
REQ-043 Bench SHALL cover: cfg_we during WAIT and cfg_we to addr 30 in IDLE -> cfg_drop pulses twice and node_w unchanged.
REQ-044 Bench SHALL cover: rst asserted mid-WAIT, then node_out_ready -> all outputs 0, IDLE, and the late node_out_ready ignored.
